wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-side writer for the single-write-port register file (drives WE/wr/wd).
- Merges two result sources into at most one write per cycle:
  - single-cycle ALU/pipeline results, which have priority;
  - long-latency LSU/divider results, buffered in a small FIFO.
- Also exports the in-flight write as a forwarding tap for operand read.

Parameters:
- DW, 32, data width
- AW, 5, register index width
- LQ_DEPTH, 4, long-latency queue entries (power of 2, >=2)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  pipeline result valid this cycle
- alu_rd  input  AW  destination register
- alu_data  input  DW  result value
- alu_stall  output  1  queue full; upstream must hold alu_* stable
- lsu_valid  input  1  long-latency result offered
- lsu_ready  output  1  result accepted when valid&&ready
- lsu_rd  input  AW  destination register
- lsu_data  input  DW  result value
- rf_we  output  1  register file write enable (registered)
- rf_wr  output  AW  write index (registered)
- rf_wd  output  DW  write data (registered)
- fwd_valid  output  1  equals rf_we
- fwd_rd  output  AW  equals rf_wr
- fwd_data  output  DW  equals rf_wd
- lq_count  output  $clog2(LQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - rf_we/rf_wr/rf_wd = 0.
  - Queue empty, lq_count = 0.
  - Reset mid-operation discards all queued entries and any pending write.
- lsu_ready = (lq_count < LQ_DEPTH), from registered count only. No same-cycle pop credit.
- alu_stall = (lq_count == LQ_DEPTH), combinational from the registered count.
- Accept LSU result (lsu_valid && lsu_ready):
  - lsu_rd != 0: push {rd,data} at the tail.
  - lsu_rd == 0: accepted and dropped, no push.
- Selection, evaluated each cycle:
  - S1: !alu_stall && alu_valid && alu_rd != 0 -> ALU wins.
  - S2: else, if queue non-empty -> pop head.
  - S3: else -> idle.
  - alu_valid with alu_rd == 0 is consumed silently and does not block S2.
  - While alu_stall, alu_* is ignored. Upstream holds it, and it is taken once the stall drops.
- Output register at posedge:
  - rf_we = selected;
  - rf_wr/rf_wd = the selected entry.
  - When idle: rf_we = 0, and rf_wr/rf_wd hold their previous values.
- Latency:
  - ALU result: rf_we in cycle N+1; register file updated at the end of N+1.
  - LSU result: at least 2 cycles (push, then pop).
- Push and pop in the same cycle: lq_count unchanged; the pointers wrap modulo LQ_DEPTH.
- Pop from a 1-entry queue while pushing: the new entry becomes head; no bypass around the FIFO.
- Ordering:
  - FIFO order is preserved among LSU results.
  - No ordering guarantee between ALU and LSU writes to the same rd; WAW avoidance is the issue scoreboard's duty.
- fwd_* mirrors rf_* so readers see data being written in the current cycle.
- Never asserts rf_we with rf_wr == 0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output wb_retire_cnt[63:0].
  - Resets to 0 and increments by 1 on every cycle with rf_we=1. It wraps at 2^64.
  - Adds output wb_drop_cnt[31:0], which counts rd==0 results consumed from either source.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle N -> rf_we=1, rf_wr=5, rf_wd=0xDEADBEEF at N+1; rf_we=0 at N+2.
- LSU only: push rd=7, data=0x1234 at N -> rf_we=1, rf_wr=7, rf_wd=0x1234 at N+2; lq_count 1 at N+1, then 0.
- Priority: queue holds rd=3 while ALU streams rd=1,2 for two cycles -> writes in order rd1, rd2, rd3; lq_count returns to 0.
- Full/stall:
  - Stimulus: with alu_valid continuously high, push LQ_DEPTH=4 entries.
  - Response: lsu_ready=0 and alu_stall=1 when count=4; queue drains one entry per cycle with ALU held; ALU result written once count<4.
- rd==0:
  - ALU rd=0 and LSU rd=0 -> no rf_we, queue unchanged.
  - ALU rd=0 with queue non-empty -> head popped the same cycle.
- Reset mid-op: assert rst_n=0 with 3 queued entries -> rf_we=0 and lq_count=0 immediately; after release, no stale writes.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: single-write-port register-file writer merging ALU and LSU results.
// Define WB_RETIRE_CNT_EN to add the wb_retire_cnt / wb_drop_cnt counters.
module wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 4,
  localparam int PW      = $clog2(LQ_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_stall,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]   wb_retire_cnt,
  output logic [31:0]   wb_drop_cnt,
`endif
  output logic [CW-1:0] lq_count
);

  logic [AW-1:0] r_q_rd   [LQ_DEPTH];
  logic [DW-1:0] r_q_data [LQ_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic          r_we;
  logic [AW-1:0] r_wr;
  logic [DW-1:0] r_wd;

  logic w_stall;
  logic w_ready;
  logic w_lsu_acc;
  logic w_push;
  logic w_alu_sel;
  logic w_pop;

  // Flow control looks only at the registered count: no same-cycle pop credit.
  assign w_stall   = (r_count == CW'(LQ_DEPTH));
  assign w_ready   = (r_count < CW'(LQ_DEPTH));
  assign w_lsu_acc = lsu_valid && w_ready;
  assign w_push    = w_lsu_acc && (lsu_rd != '0);
  assign w_alu_sel = !w_stall && alu_valid
                   && (alu_rd != '0);
  assign w_pop     = !w_alu_sel && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wp]   <= lsu_rd;
      r_q_data[r_wp] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Idle cycles drop the enable but keep the last index/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_wr <= '0;
      r_wd <= '0;
    end else begin
      unique case (1'b1)
        w_alu_sel: begin
          r_we <= 1'b1;
          r_wr <= alu_rd;
          r_wd <= alu_data;
        end
        w_pop: begin
          r_we <= 1'b1;
          r_wr <= r_q_rd[r_rp];
          r_wd <= r_q_data[r_rp];
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_alu_drop;
  logic        w_lsu_drop;

  assign w_alu_drop = !w_stall && alu_valid
                    && (alu_rd == '0);
  assign w_lsu_drop = w_lsu_acc && (lsu_rd == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (r_we) r_retire_cnt <= r_retire_cnt + 64'd1;
      r_drop_cnt <= r_drop_cnt
                  + {31'd0, w_alu_drop}
                  + {31'd0, w_lsu_drop};
    end
  end

  assign wb_retire_cnt = r_retire_cnt;
  assign wb_drop_cnt   = r_drop_cnt;
`endif

  assign alu_stall = w_stall;
  assign lsu_ready = w_ready;
  assign lq_count  = r_count;
  assign rf_we     = r_we;
  assign rf_wr     = r_wr;
  assign rf_wd     = r_wd;
  assign fwd_valid = r_we;
  assign fwd_rd    = r_wr;
  assign fwd_data  = r_wd;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with a queue-based reference model.
// Optional WB_RETIRE_CNT_EN counters are modelled when the macro is defined.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          lsu_valid = 1'b0;
  logic [AW-1:0] lsu_rd = '0;
  logic [DW-1:0] lsu_data = '0;
  logic          alu_stall;
  logic          lsu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_wd;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] lq_count;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]   wb_retire_cnt;
  logic [31:0]   wb_drop_cnt;
`endif

  wb_arbiter #(.DW(DW), .AW(AW), .LQ_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
`ifdef WB_RETIRE_CNT_EN
    .wb_retire_cnt(wb_retire_cnt),
    .wb_drop_cnt(wb_drop_cnt),
`endif
    .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  longint unsigned m_ret = 0;
  int unsigned     m_drop = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    q.delete();
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
    m_ret = 0;
    m_drop = 0;
  endtask

  // Model of one clock edge, built from the selection rules on a plain queue.
  task automatic m_edge();
    bit full;
    bit rdy;
    ent_t e;
    full = (q.size() == D);
    rdy  = (q.size() < D);
    if (m_we) m_ret++;
    if (!full && alu_valid && alu_rd == 0) m_drop++;
    if (lsu_valid && rdy && lsu_rd == 0) m_drop++;
    if (!full && alu_valid && alu_rd != 0) begin
      m_we = 1'b1;
      m_wr = alu_rd;
      m_wd = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1;
      m_wr = e.rd;
      m_wd = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (lsu_valid && rdy && lsu_rd != 0)
      q.push_back('{rd: lsu_rd, d: lsu_data});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_clear();
    else m_edge();
    #1;
  endtask

  task automatic drv(input logic av, input int ar, input logic [DW-1:0] ad,
                     input logic lv, input int lr, input logic [DW-1:0] ld);
    alu_valid = av;
    alu_rd    = AW'(ar);
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = AW'(lr);
    lsu_data  = ld;
  endtask

  task automatic idle();
    drv(1'b0, 0, '0, 1'b0, 0, '0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_wr", 64'(rf_wr), 64'(m_wr));
    chk("rf_wd", 64'(rf_wd), 64'(m_wd));
    chk("fwd_valid", 64'(fwd_valid), 64'(m_we));
    chk("fwd_rd", 64'(fwd_rd), 64'(m_wr));
    chk("fwd_data", 64'(fwd_data), 64'(m_wd));
    chk("lq_count", 64'(lq_count), 64'(q.size()));
    chk("lsu_ready", 64'(lsu_ready), 64'(q.size() < D));
    chk("alu_stall", 64'(alu_stall), 64'(q.size() == D));
    if (rf_we) chk("we_rd0", 64'(rf_wr == '0), 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", wb_retire_cnt, 64'(m_ret));
    chk("drop_cnt", 64'(wb_drop_cnt), 64'(m_drop));
`endif
  end

  initial begin
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_cnt", 64'(lq_count), 64'd0);
    chk("rst_wd", 64'(rf_wd), 64'd0);

    // ALU only
    drv(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0);
    tick();
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_wr", 64'(rf_wr), 64'd5);
    chk("alu_wd", 64'(rf_wd), 64'hDEADBEEF);
    idle();
    tick();
    chk("alu_we_off", 64'(rf_we), 64'd0);
    chk("alu_wd_hold", 64'(rf_wd), 64'hDEADBEEF);

    // LSU only
    drv(1'b0, 0, '0, 1'b1, 7, 32'h1234);
    tick();
    chk("lsu_cnt1", 64'(lq_count), 64'd1);
    chk("lsu_we0", 64'(rf_we), 64'd0);
    idle();
    tick();
    chk("lsu_we", 64'(rf_we), 64'd1);
    chk("lsu_wr", 64'(rf_wr), 64'd7);
    chk("lsu_wd", 64'(rf_wd), 64'h1234);
    chk("lsu_cnt0", 64'(lq_count), 64'd0);

    // ALU priority over a queued entry
    drv(1'b0, 0, '0, 1'b1, 3, 32'h33);
    tick();
    drv(1'b1, 1, 32'h11, 1'b0, 0, '0);
    tick();
    chk("pri_wr1", 64'(rf_wr), 64'd1);
    drv(1'b1, 2, 32'h22, 1'b0, 0, '0);
    tick();
    chk("pri_wr2", 64'(rf_wr), 64'd2);
    chk("pri_cnt", 64'(lq_count), 64'd1);
    idle();
    tick();
    chk("pri_wr3", 64'(rf_wr), 64'd3);
    chk("pri_wd3", 64'(rf_wd), 64'h33);
    chk("pri_cnt0", 64'(lq_count), 64'd0);

    // Fill to full with ALU continuously valid
    for (int i = 0; i < D; i++) begin
      drv(1'b1, 9, 32'hA9, 1'b1, 10 + i, DW'(10 + i));
      tick();
    end
    chk("full_cnt", 64'(lq_count), 64'd4);
    chk("full_stall", 64'(alu_stall), 64'd1);
    chk("full_ready", 64'(lsu_ready), 64'd0);
    drv(1'b1, 9, 32'hA9, 1'b0, 0, '0);
    tick();
    chk("drain_wr", 64'(rf_wr), 64'd10);
    chk("drain_cnt", 64'(lq_count), 64'd3);
    chk("drain_stall", 64'(alu_stall), 64'd0);
    tick();
    chk("held_alu_wr", 64'(rf_wr), 64'd9);
    chk("held_alu_wd", 64'(rf_wd), 64'hA9);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_seq", 64'(rf_wr), 64'(11 + i));
    end
    chk("drain_empty", 64'(lq_count), 64'd0);

    // rd==0 from both sources
    drv(1'b1, 0, 32'hBAD, 1'b1, 0, 32'hBAD);
    tick();
    chk("rd0_we", 64'(rf_we), 64'd0);
    chk("rd0_cnt", 64'(lq_count), 64'd0);
    drv(1'b0, 0, '0, 1'b1, 4, 32'h44);
    tick();
    drv(1'b1, 0, 32'hBAD, 1'b0, 0, '0);
    tick();
    chk("rd0_pop_we", 64'(rf_we), 64'd1);
    chk("rd0_pop_wr", 64'(rf_wr), 64'd4);

    // Push and pop on a one-entry queue
    drv(1'b0, 0, '0, 1'b1, 5, 32'h55);
    tick();
    drv(1'b0, 0, '0, 1'b1, 6, 32'h66);
    tick();
    chk("pp_wr", 64'(rf_wr), 64'd5);
    chk("pp_cnt", 64'(lq_count), 64'd1);
    idle();
    tick();
    chk("pp_wr2", 64'(rf_wr), 64'd6);
    chk("pp_wd2", 64'(rf_wd), 64'h66);

    // Reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1, DW'(100 + i), 1'b1, 20 + i, DW'(20 + i));
      tick();
    end
    chk("pre_rst_cnt", 64'(lq_count), 64'd3);
    drv(1'b1, 1, 32'h77, 1'b0, 0, '0);
    rst_n = 1'b0;
    m_clear();
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_cnt", 64'(lq_count), 64'd0);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 64'(rf_we), 64'd0);
    end
    chk("post_rst_cnt", 64'(lq_count), 64'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
